vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 20 ++
 rtl/vga_axis_counter.sv | 24 ++
 rtl/vga_timing_gen.sv | 81 ++++++++
 tb/tb_vga_timing_gen.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants shared by the VGA timing generator and its counters.
package vga_timing_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int unsigned CNT_W = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL);

    localparam logic SYNC_ACTIVE = 1'b0;

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-MAX position counter for one VGA axis; advances on en and flags the wrap edge.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned MAX = H_TOTAL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    assign wrap = en && (cnt == CNT_W'(MAX - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-tick-enabled h/v counters, combinational sync/DE/coordinate decode,
// and registered line/frame start pulses.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
    parameter int unsigned H_FP        = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP        = vga_timing_pkg::H_BP,
    parameter int unsigned V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
    parameter int unsigned V_FP        = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP        = vga_timing_pkg::V_BP,
    parameter logic        SYNC_ACTIVE = vga_timing_pkg::SYNC_ACTIVE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p_tick,
    output logic             h_sync,
    output logic             v_sync,
    output logic             de,
    output logic [CNT_W-1:0] x_pixel,
    output logic [CNT_W-1:0] y_pixel,
    output logic             line_start,
    output logic             frame_start
);

    localparam int unsigned HTotal = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTotal = V_VISIBLE + V_FP + V_SYNC + V_BP;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             h_in_sync;
    logic             v_in_sync;

    vga_axis_counter #(
        .MAX (HTotal)
    ) u_h_counter (
        .clk   (clk),
        .reset (reset),
        .en    (p_tick),
        .cnt   (h_cnt),
        .wrap  (h_wrap)
    );

    // Vertical axis only sees an enable on the horizontal wrap, so v_wrap implies h_wrap.
    vga_axis_counter #(
        .MAX (VTotal)
    ) u_v_counter (
        .clk   (clk),
        .reset (reset),
        .en    (h_wrap),
        .cnt   (v_cnt),
        .wrap  (v_wrap)
    );

    always_comb begin
        h_in_sync = (h_cnt >= CNT_W'(H_VISIBLE + H_FP)) &&
                    (h_cnt <  CNT_W'(H_VISIBLE + H_FP + H_SYNC));
        v_in_sync = (v_cnt >= CNT_W'(V_VISIBLE + V_FP)) &&
                    (v_cnt <  CNT_W'(V_VISIBLE + V_FP + V_SYNC));
        h_sync    = h_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        v_sync    = v_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        de        = (h_cnt < CNT_W'(H_VISIBLE)) && (v_cnt < CNT_W'(V_VISIBLE));
        x_pixel   = de ? h_cnt : '0;
        y_pixel   = de ? v_cnt : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= h_wrap;
            frame_start <= v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen against a tick-count raster model; vertical geometry is
// shortened (12 lines) so several whole frames fit in a short run.
module tb_vga_timing_gen;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = 800;
    localparam int V_VISIBLE = 6;
    localparam int V_FP      = 2;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 2;
    localparam int V_TOTAL   = 12;
    localparam int FRAME     = H_TOTAL * V_TOTAL;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       p_tick = 1'b0;
    logic       h_sync, v_sync, de, line_start, frame_start;
    logic [9:0] x_pixel, y_pixel;

    int checks = 0;
    int failures = 0;
    int n_ticks = 0;
    int cyc = 0;
    bit line_exp = 1'b0;
    bit frame_exp = 1'b0;

    wire [24:0] obs = {h_sync, v_sync, de, x_pixel, y_pixel, line_start, frame_start};
    localparam logic [24:0] RESET_VEC = {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0, 1'b0};

    vga_timing_gen #(
        .H_VISIBLE   (H_VISIBLE),
        .H_FP        (H_FP),
        .H_SYNC      (H_SYNC),
        .H_BP        (H_BP),
        .V_VISIBLE   (V_VISIBLE),
        .V_FP        (V_FP),
        .V_SYNC      (V_SYNC),
        .V_BP        (V_BP),
        .SYNC_ACTIVE (1'b0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .p_tick      (p_tick),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .de          (de),
        .x_pixel     (x_pixel),
        .y_pixel     (y_pixel),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Raster position follows directly from the number of ticks seen since reset.
    function automatic logic [24:0] model_vec();
        int h;
        int v;
        bit hs;
        bit vs;
        bit d;
        h  = n_ticks % H_TOTAL;
        v  = (n_ticks / H_TOTAL) % V_TOTAL;
        hs = !((h >= H_VISIBLE + H_FP) && (h < H_VISIBLE + H_FP + H_SYNC));
        vs = !((v >= V_VISIBLE + V_FP) && (v < V_VISIBLE + V_FP + V_SYNC));
        d  = (h < H_VISIBLE) && (v < V_VISIBLE);
        return {hs, vs, d, d ? 10'(h) : 10'd0, d ? 10'(v) : 10'd0, line_exp, frame_exp};
    endfunction

    task automatic step(input bit t);
        p_tick = t;
        @(posedge clk);
        cyc++;
        if (reset || !t) begin
            line_exp  = 1'b0;
            frame_exp = 1'b0;
        end else begin
            line_exp  = (n_ticks % H_TOTAL) == H_TOTAL - 1;
            frame_exp = (n_ticks % FRAME) == FRAME - 1;
            n_ticks++;
        end
        #1;
    endtask

    // Asserts reset mid-cycle, then releases it after an edge that carries a (ignored) tick.
    task automatic apply_reset();
        reset     = 1'b1;
        n_ticks   = 0;
        line_exp  = 1'b0;
        frame_exp = 1'b0;
        step(1'b1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b0);
        checks++;
        if (obs !== RESET_VEC) begin
            failures++;
            $display("FAIL reset_values: got %h want %h", obs, RESET_VEC);
        end
        apply_reset();
        #1;
        checks++;
        if (obs !== model_vec()) begin
            failures++;
            $display("FAIL tick_at_release: got %h want %h", obs, model_vec());
        end
        for (int i = 0; i < 3; i++) step(1'b0);
        step(1'b1);
        checks++;
        if (x_pixel !== 10'd1 || obs !== model_vec()) begin
            failures++;
            $display("FAIL first_advance: got %h want %h", obs, model_vec());
        end
    endtask

    task automatic test_line();
        int de_cnt = 0;
        int hs_low = 0;
        int ls_cnt = 0;
        int bad = 0;
        apply_reset();
        for (int k = 0; k < H_TOTAL; k++) begin
            for (int s = 0; s < 4; s++) begin
                step(s == 0);
                if (s == 0) begin
                    de_cnt += int'(de);
                    hs_low += int'(!h_sync);
                end
                ls_cnt += int'(line_start);
                checks++;
                if (obs !== model_vec()) begin
                    failures++;
                    if (bad++ < 5) $display("FAIL line_decode: got %h want %h", obs, model_vec());
                end
            end
        end
        checks += 3;
        if (de_cnt != H_VISIBLE) begin
            failures++;
            $display("FAIL line_de_ticks: got %0d want %0d", de_cnt, H_VISIBLE);
        end
        if (hs_low != H_SYNC) begin
            failures++;
            $display("FAIL line_hsync_ticks: got %0d want %0d", hs_low, H_SYNC);
        end
        if (ls_cnt != 1) begin
            failures++;
            $display("FAIL line_start_count: got %0d want 1", ls_cnt);
        end
    endtask

    task automatic test_frame();
        int vs_low = 0;
        int fs_cnt = 0;
        int y_max = 0;
        int last_ls = -1;
        int bad = 0;
        for (int k = 0; k < FRAME - H_TOTAL; k++) begin
            for (int s = 0; s < 4; s++) begin
                step(s == 0);
                if (s == 0) vs_low += int'(!v_sync);
                if (de && int'(y_pixel) > y_max) y_max = int'(y_pixel);
                fs_cnt += int'(frame_start);
                if (line_start) begin
                    if (last_ls >= 0) begin
                        checks++;
                        if (cyc - last_ls != 4 * H_TOTAL) begin
                            failures++;
                            $display("FAIL line_period_div4: got %0d want %0d",
                                     cyc - last_ls, 4 * H_TOTAL);
                        end
                    end
                    last_ls = cyc;
                end
                checks++;
                if (obs !== model_vec()) begin
                    failures++;
                    if (bad++ < 5) $display("FAIL frame_decode: got %h want %h", obs, model_vec());
                end
            end
        end
        checks += 3;
        if (vs_low != V_SYNC * H_TOTAL) begin
            failures++;
            $display("FAIL frame_vsync_ticks: got %0d want %0d", vs_low, V_SYNC * H_TOTAL);
        end
        if (fs_cnt != 1) begin
            failures++;
            $display("FAIL frame_start_count: got %0d want 1", fs_cnt);
        end
        if (y_max != V_VISIBLE - 1) begin
            failures++;
            $display("FAIL frame_y_max: got %0d want %0d", y_max, V_VISIBLE - 1);
        end
    endtask

    task automatic test_stall();
        logic [24:0] frozen;
        int bad = 0;
        for (int i = 0; i < H_TOTAL && (n_ticks % H_TOTAL) != 300; i++) step(1'b1);
        step(1'b0);
        frozen = model_vec();
        for (int i = 0; i < 1000; i++) begin
            step(1'b0);
            checks++;
            if (obs !== frozen) begin
                failures++;
                if (bad++ < 5) $display("FAIL stall_frozen: got %h want %h", obs, frozen);
            end
        end
        step(1'b1);
        checks++;
        if (x_pixel !== 10'd301 || obs !== model_vec()) begin
            failures++;
            $display("FAIL stall_resume: got %h want %h", obs, model_vec());
        end
    endtask

    task automatic test_continuous();
        int last_ls = -1;
        int last_fs = -1;
        int frames = 0;
        int bad = 0;
        bit prev_ls = 1'b0;
        bit prev_fs = 1'b0;
        for (int i = 0; i < 2 * FRAME + 10 && frames < 2; i++) begin
            step(1'b1);
            checks++;
            if (obs !== model_vec() || (prev_ls && line_start) || (prev_fs && frame_start)) begin
                failures++;
                if (bad++ < 5) $display("FAIL cont_decode: got %h want %h", obs, model_vec());
            end
            if (line_start) begin
                if (last_ls >= 0) begin
                    checks++;
                    if (cyc - last_ls != H_TOTAL) begin
                        failures++;
                        $display("FAIL cont_line_period: got %0d want %0d", cyc - last_ls, H_TOTAL);
                    end
                end
                last_ls = cyc;
            end
            if (frame_start) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (cyc - last_fs != FRAME) begin
                        failures++;
                        $display("FAIL cont_frame_period: got %0d want %0d", cyc - last_fs, FRAME);
                    end
                end
                last_fs = cyc;
                frames++;
            end
            prev_ls = line_start;
            prev_fs = frame_start;
        end
        checks++;
        if (frames < 2) begin
            failures++;
            $display("FAIL cont_timeout: got %0d frame_start pulses want 2", frames);
        end
    endtask

    task automatic test_boundary();
        for (int i = 0; i < FRAME && (n_ticks % FRAME) != FRAME - 1; i++) step(1'b1);
        step(1'b1);
        checks++;
        if ({line_start, frame_start, de, x_pixel, y_pixel} !== {3'b111, 20'd0}) begin
            failures++;
            $display("FAIL boundary_wrap: got ls=%b fs=%b de=%b x=%0d y=%0d want 1 1 1 0 0",
                     line_start, frame_start, de, x_pixel, y_pixel);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== RESET_VEC) begin
            failures++;
            $display("FAIL boundary_pulse_clear: got %h want %h", obs, RESET_VEC);
        end
        apply_reset();
    endtask

    task automatic test_reset_mid();
        int target = (V_VISIBLE + V_FP + V_SYNC - 1) * H_TOTAL + 700;
        int ticks = 0;
        int bad = 0;
        bit seen = 1'b0;
        for (int i = 0; i < FRAME && (n_ticks % FRAME) != target; i++) step(1'b1);
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== RESET_VEC) begin
            failures++;
            $display("FAIL reset_mid_immediate: got %h want %h", obs, RESET_VEC);
        end
        apply_reset();
        for (int k = 0; k < 900 && !seen; k++) begin
            for (int s = 0; s < 4 && !seen; s++) begin
                step(s == 0);
                if (s == 0) ticks++;
                seen = line_start;
                checks++;
                if (obs !== model_vec()) begin
                    failures++;
                    if (bad++ < 5) $display("FAIL reset_mid_decode: got %h want %h", obs, model_vec());
                end
            end
        end
        checks++;
        if (!seen || ticks != H_TOTAL) begin
            failures++;
            $display("FAIL reset_mid_first_line: got %0d ticks (seen=%0b) want %0d",
                     ticks, seen, H_TOTAL);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                n_ticks = 0;
                line_exp = 1'b0;
                frame_exp = 1'b0;
                #1;
                checks++;
                if (obs !== RESET_VEC) begin
                    failures++;
                    $display("FAIL random_reset: got %h want %h", obs, RESET_VEC);
                end
                step(1'($urandom_range(0, 1)));
                reset = 1'b0;
            end
            step(1'($urandom_range(0, 1)));
            checks++;
            if (obs !== model_vec()) begin
                failures++;
                if (bad++ < 5) $display("FAIL random_decode: got %h want %h", obs, model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_stall();
        test_continuous();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
